// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: latches button presses, grants WALK at the next red onset,
// then a flashing DONT_WALK countdown; aborts with a conflict pulse if red is lost.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYCLES  = 5,
  parameter int unsigned FLASH_CYCLES = 3,
  parameter int unsigned COUNT_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               red,
  input  logic               orange,
  input  logic               green,
  input  logic               ped_button,
  output logic               walk,
  output logic               dont_walk,
  output logic               req_pending,
  output logic [COUNT_W-1:0] countdown,
  output logic               conflict
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StWalk,
    StFlash
  } state_e;

  localparam logic [COUNT_W-1:0] WalkLoad  = COUNT_W'(WALK_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FlashLoad = COUNT_W'(FLASH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               dw_q, dw_d;
  logic               conflict_q, conflict_d;
  logic               btn_q;
  logic               red_q;

  logic               red_ok;
  logic               press;
  logic               red_rise;

  // Only a clean red (no other lamp lit) gives pedestrians right-of-way.
  assign red_ok   = red & ~orange & ~green;
  assign press    = ped_button & ~btn_q;
  assign red_rise = red_ok & ~red_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    dw_d       = dw_q;
    conflict_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A red onset in the same cycle as the press is deliberately not used.
        if (press) begin
          state_d   = StArmed;
          pending_d = 1'b1;
        end
      end

      StArmed: begin
        if (red_rise) begin
          state_d   = StWalk;
          cnt_d     = WalkLoad;
          pending_d = 1'b0;
          dw_d      = 1'b0;
        end
      end

      StWalk, StFlash: begin
        if (press) begin
          pending_d = 1'b1;
        end
        if (!red_ok) begin
          conflict_d = 1'b1;
          state_d    = pending_d ? StArmed : StIdle;
          cnt_d      = '0;
          dw_d       = 1'b1;
        end else if (cnt_q == '0) begin
          dw_d = 1'b1;
          if (state_q == StWalk) begin
            state_d = StFlash;
            cnt_d   = FlashLoad;
          end else begin
            state_d = pending_d ? StArmed : StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (state_q == StFlash) begin
            dw_d = ~dw_q;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      dw_q       <= 1'b1;
      conflict_q <= 1'b0;
      btn_q      <= 1'b0;
      // Treat red as already seen so no red onset is detected right after reset.
      red_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      dw_q       <= dw_d;
      conflict_q <= conflict_d;
      btn_q      <= ped_button;
      red_q      <= red_ok;
    end
  end

  // The counter is held at zero outside WALK/FLASH, so it drives countdown directly.
  assign walk        = (state_q == StWalk);
  assign dont_walk   = dw_q;
  assign req_pending = pending_q;
  assign countdown   = cnt_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: the driver queues the expected lamp state per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_ped_crossing_ctrl;

  typedef struct packed {
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [3:0] countdown;
    logic       conflict;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       red;
  logic       orange;
  logic       green;
  logic       ped_button;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [3:0] countdown;
  logic       conflict;

  exp_t  exp_q[$];
  string name_q[$];
  string tname;
  int    n_cmp;
  int    n_fail;
  int    ph;
  int    cyc;
  logic  rst;
  logic  btn_hold;
  logic  force_orange;

  ped_crossing_ctrl #(
    .WALK_CYCLES (5),
    .FLASH_CYCLES(3),
    .COUNT_W     (4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .red        (red),
    .orange     (orange),
    .green      (green),
    .ped_button (ped_button),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic w, input logic dw, input logic rp, input int cd,
                              input logic cf);
    exp_t e;
    e.walk        = w;
    e.dont_walk   = dw;
    e.req_pending = rp;
    e.countdown   = 4'(cd);
    e.conflict    = cf;
    return e;
  endfunction

  localparam exp_t EIdle  = '{walk: 1'b0, dont_walk: 1'b1, req_pending: 1'b0, countdown: 4'd0,
                              conflict: 1'b0};
  localparam exp_t EArmed = '{walk: 1'b0, dont_walk: 1'b1, req_pending: 1'b1, countdown: 4'd0,
                              conflict: 1'b0};

  // Monitor: every cycle with a queued expectation is one comparison.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = '{walk: walk, dont_walk: dont_walk, req_pending: req_pending,
              countdown: countdown, conflict: conflict};
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got w=%b dw=%b rp=%b cd=%0d cf=%b want w=%b dw=%b rp=%b cd=%0d cf=%b",
                 nm, cyc, got.walk, got.dont_walk, got.req_pending, got.countdown, got.conflict,
                 e.walk, e.dont_walk, e.req_pending, e.countdown, e.conflict);
      end
    end
  end

  // Drive one cycle: lights from the 16-cycle model (red 0-8, orange 9-11, green 12-15),
  // and queue the outputs expected during this cycle.
  task automatic tick(input logic btn, input exp_t e);
    reset      = rst;
    ped_button = btn | btn_hold;
    if (force_orange) begin
      red    = 1'b0;
      orange = 1'b1;
      green  = 1'b0;
    end else begin
      red    = (ph <= 8);
      orange = (ph >= 9) && (ph <= 11);
      green  = (ph >= 12);
    end
    exp_q.push_back(e);
    name_q.push_back(tname);
    @(posedge clk);
    #1;
    ph  = (ph + 1) % 16;
    cyc++;
  endtask

  // Run up to the next red onset (phase 0), optionally pressing at phase 13.
  task automatic wait_red(input logic do_press, input logic armed);
    do begin
      tick(do_press && (ph == 13), (armed || (do_press && ph >= 14)) ? EArmed : EIdle);
    end while (ph != 0);
  endtask

  // From an armed red onset: WALK 4..0 then FLASH 2..0; pidx<0 means no press during WALK.
  task automatic service(input int pidx);
    tick(1'b0, EArmed);
    for (int i = 0; i < 5; i++) begin
      tick(i == pidx, mk(1'b1, 1'b0, (pidx >= 0) && (i > pidx), 4 - i, 1'b0));
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, mk(1'b0, i != 1, pidx >= 0, 2 - i, 1'b0));
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    cyc          = 0;
    ph           = 0;
    btn_hold     = 1'b0;
    force_orange = 1'b0;
    rst          = 1'b1;
    reset        = 1'b1;
    red          = 1'b1;
    orange       = 1'b0;
    green        = 1'b0;
    ped_button   = 1'b0;

    tname = "reset";
    @(posedge clk);
    #1;
    tick(1'b0, EIdle);
    tick(1'b0, EIdle);
    rst = 1'b0;
    ph  = 0;

    tname = "idle_no_press";
    repeat (32) tick(1'b0, EIdle);

    tname = "press_green_walk";
    wait_red(1'b1, 1'b0);
    service(-1);

    tname = "press_during_walk";
    wait_red(1'b1, 1'b0);
    service(2);
    wait_red(1'b0, 1'b1);
    service(-1);

    tname = "conflict";
    wait_red(1'b1, 1'b0);
    tick(1'b0, EArmed);
    tick(1'b0, mk(1'b1, 1'b0, 1'b0, 4, 1'b0));
    tick(1'b0, mk(1'b1, 1'b0, 1'b0, 3, 1'b0));
    force_orange = 1'b1;
    tick(1'b0, mk(1'b1, 1'b0, 1'b0, 2, 1'b0));
    force_orange = 1'b0;
    tick(1'b0, mk(1'b0, 1'b1, 1'b0, 0, 1'b1));
    tick(1'b0, EIdle);
    wait_red(1'b0, 1'b0);
    repeat (9) tick(1'b0, EIdle);

    tname = "press_at_red_rise";
    wait_red(1'b0, 1'b0);
    tick(1'b1, EIdle);
    wait_red(1'b0, 1'b1);
    service(-1);

    tname = "reset_in_flash";
    wait_red(1'b1, 1'b0);
    tick(1'b0, EArmed);
    tick(1'b0, mk(1'b1, 1'b0, 1'b0, 4, 1'b0));
    tick(1'b1, mk(1'b1, 1'b0, 1'b0, 3, 1'b0));
    tick(1'b0, mk(1'b1, 1'b0, 1'b1, 2, 1'b0));
    tick(1'b0, mk(1'b1, 1'b0, 1'b1, 1, 1'b0));
    tick(1'b0, mk(1'b1, 1'b0, 1'b1, 0, 1'b0));
    rst = 1'b1;
    tick(1'b0, mk(1'b0, 1'b1, 1'b1, 2, 1'b0));
    rst = 1'b0;
    tick(1'b0, EIdle);
    tick(1'b0, EIdle);

    tname = "held_button";
    while (ph != 13) tick(1'b0, EIdle);
    btn_hold = 1'b1;
    tick(1'b0, EIdle);
    tick(1'b0, EArmed);
    tick(1'b0, EArmed);
    service(-1);
    repeat (16) tick(1'b0, EIdle);
    btn_hold = 1'b0;

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
